// File: rtl/watch_mode_ctrl.sv
// Front-end controller for the watch: debounces the board buttons into press events,
// selects the display mode and sequences the stopwatch/timer run, pause and clear commands.
module watch_mode_ctrl #(
    parameter int DEB_CYCLES = 250000,
    parameter int CLR_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] btn_n,
    input  logic       timer_done,
    output logic [3:0] state,
    output logic [3:0] flag,
    output logic [7:0] btn_evt
);

    localparam int TW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int CW = $clog2(CLR_CYCLES) + 1;

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'd0,
        MODE_STOPWATCH = 2'd1,
        MODE_TIMER     = 2'd2,
        MODE_ALARM     = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        SUB_IDLE   = 2'd0,
        SUB_RUN    = 2'd1,
        SUB_PAUSED = 2'd2,
        SUB_CLEAR  = 2'd3
    } sub_t;

    // ------------------------------------------------------------------
    // Input conditioning and debounce
    // ------------------------------------------------------------------
    logic [7:0]    sync_1;
    logic [7:0]    sync_2;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [7:0]    sample;
    logic [7:0]    deb;
    logic [7:0]    agree;
    logic [7:0]    deb_next;

    assign tick     = (tick_cnt == TW'(DEB_CYCLES - 1));
    assign agree    = ~(sync_2 ^ sample);
    assign deb_next = (agree & sync_2) | (~agree & deb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1   <= '0;
            sync_2   <= '0;
            tick_cnt <= '0;
            sample   <= '0;
            deb      <= '0;
            btn_evt  <= '0;
        end else begin
            sync_1   <= ~btn_n;
            sync_2   <= sync_1;
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (tick) begin
                sample  <= sync_2;
                deb     <= deb_next;
                btn_evt <= deb_next & ~deb;
            end else begin
                btn_evt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode and sub-sequencer next-state logic
    // ------------------------------------------------------------------
    logic          evt_mode;
    logic          evt_ss;
    logic          evt_clr;
    mode_t         mode;
    mode_t         mode_next;
    sub_t          sw_st;
    sub_t          sw_next;
    sub_t          tm_st;
    sub_t          tm_next;
    logic [CW-1:0] sw_cnt;
    logic [CW-1:0] sw_cnt_next;
    logic [CW-1:0] tm_cnt;
    logic [CW-1:0] tm_cnt_next;
    logic [3:0]    flag_next;

    assign evt_mode = btn_evt[0];
    assign evt_ss   = btn_evt[1];
    assign evt_clr  = btn_evt[2];

    // CLEAR runs to completion whether or not its mode is still selected;
    // a clear request outranks START/STOP whenever it is legal.
    function automatic sub_t sub_step(input sub_t cur, input logic sel,
                                      input logic ss, input logic clr,
                                      input logic hold_done);
        sub_t nxt;
        nxt = cur;
        case (cur)
            SUB_IDLE: begin
                if (sel && clr)     nxt = SUB_CLEAR;
                else if (sel && ss) nxt = SUB_RUN;
            end
            SUB_RUN: begin
                if (sel && ss) nxt = SUB_PAUSED;
            end
            SUB_PAUSED: begin
                if (sel && clr)     nxt = SUB_CLEAR;
                else if (sel && ss) nxt = SUB_RUN;
            end
            SUB_CLEAR: begin
                if (hold_done) nxt = SUB_IDLE;
            end
            default: nxt = SUB_IDLE;
        endcase
        return nxt;
    endfunction

    function automatic logic [3:0] flag_code(input sub_t st);
        logic [3:0] code;
        case (st)
            SUB_RUN:    code = 4'd7;
            SUB_PAUSED: code = 4'd6;
            SUB_CLEAR:  code = 4'd5;
            default:    code = 4'd0;
        endcase
        return code;
    endfunction

    always_comb begin
        mode_next   = mode;
        sw_next     = SUB_IDLE;
        tm_next     = SUB_IDLE;
        sw_cnt_next = '0;
        tm_cnt_next = '0;
        flag_next   = 4'd0;

        if (evt_mode) mode_next = mode_t'(mode + 2'd1);

        // Actions are steered by the mode selected before any MODE event this cycle.
        sw_next = sub_step(sw_st, mode == MODE_STOPWATCH, evt_ss, evt_clr,
                           sw_cnt == CW'(CLR_CYCLES - 1));
        tm_next = sub_step(tm_st, mode == MODE_TIMER, evt_ss, evt_clr,
                           tm_cnt == CW'(CLR_CYCLES - 1));
        if (timer_done && tm_st == SUB_RUN) tm_next = SUB_IDLE;

        if (sw_st == SUB_CLEAR && sw_next == SUB_CLEAR) sw_cnt_next = sw_cnt + CW'(1);
        if (tm_st == SUB_CLEAR && tm_next == SUB_CLEAR) tm_cnt_next = tm_cnt + CW'(1);

        case (mode_next)
            MODE_STOPWATCH: flag_next = flag_code(sw_next);
            MODE_TIMER:     flag_next = flag_code(tm_next);
            default:        flag_next = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= MODE_STOPWATCH;
            sw_st  <= SUB_IDLE;
            tm_st  <= SUB_IDLE;
            sw_cnt <= '0;
            tm_cnt <= '0;
            flag   <= 4'd0;
        end else begin
            mode   <= mode_next;
            sw_st  <= sw_next;
            tm_st  <= tm_next;
            sw_cnt <= sw_cnt_next;
            tm_cnt <= tm_cnt_next;
            flag   <= flag_next;
        end
    end

    assign state = {2'b00, mode};

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Bench for watch_mode_ctrl: drives button presses, predicts events, mode and flag
// from a behavioural model and compares them as the controller produces its events.
module tb_watch_mode_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] btn_n;
    logic       timer_done;
    logic [3:0] state;
    logic [3:0] flag;
    logic [7:0] btn_evt;

    int n_checks = 0;
    int n_errors = 0;

    // entry: {event mask[15:8], state[7:4], flag[3:0]}
    logic [15:0] exp_q[$];

    // model: sub-state 0 IDLE, 1 RUN, 2 PAUSED, 3 CLEAR
    int m_mode = 1;
    int m_sw   = 0;
    int m_tm   = 0;

    watch_mode_ctrl #(
        .DEB_CYCLES(4),
        .CLR_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_n     (btn_n),
        .timer_done(timer_done),
        .state     (state),
        .flag      (flag),
        .btn_evt   (btn_evt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic int sub_step(input int cur, input bit sel, input bit ss, input bit clr);
        if (!sel || cur == 3) return cur;
        if (clr && (cur == 0 || cur == 2)) return 3;
        if (ss) return (cur == 1) ? 2 : 1;
        return cur;
    endfunction

    function automatic int enc(input int s);
        case (s)
            1:       return 7;
            2:       return 6;
            3:       return 5;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_flag();
        if (m_mode == 1) return enc(m_sw);
        if (m_mode == 2) return enc(m_tm);
        return 0;
    endfunction

    // ---------------- drivers ----------------
    task automatic press(input logic [7:0] mask, input int hold);
        int f;
        m_sw = sub_step(m_sw, m_mode == 1, mask[1], mask[2]);
        m_tm = sub_step(m_tm, m_mode == 2, mask[1], mask[2]);
        if (mask[0]) m_mode = (m_mode + 1) % 4;
        f = exp_flag();
        exp_q.push_back({mask, 4'(m_mode), 4'(f)});
        if (m_sw == 3) m_sw = 0;
        if (m_tm == 3) m_tm = 0;
        @(negedge clk);
        btn_n = ~mask;
        repeat (hold) @(negedge clk);
        btn_n = 8'hFF;
        repeat (20) @(negedge clk);
        check("evt_seen", 16'(exp_q.size()), 16'd0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic press_rand(input logic [7:0] mask);
        press(mask, $urandom_range(14, 30));
    endtask

    task automatic glitch(input int bit_idx);
        @(negedge clk);
        btn_n[bit_idx] = 1'b0;
        @(negedge clk);
        btn_n[bit_idx] = 1'b1;
        repeat ($urandom_range(8, 12)) @(negedge clk);
    endtask

    task automatic pulse_done();
        if (m_tm == 1) m_tm = 0;
        @(negedge clk);
        timer_done = 1'b1;
        @(negedge clk);
        timer_done = 1'b0;
        check("done_state", {12'h0, state}, 16'(m_mode));
        check("done_flag", {12'h0, flag}, 16'(exp_flag()));
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (btn_evt !== 8'h00) begin
                if (exp_q.size() == 0) begin
                    check("evt_unexpected", {8'h00, btn_evt}, 16'h0000);
                end else begin
                    e = exp_q.pop_front();
                    check("evt", {8'h00, btn_evt}, {8'h00, e[15:8]});
                    @(negedge clk);
                    check("state", {12'h0, state}, {12'h0, e[7:4]});
                    check("flag", {12'h0, flag}, {12'h0, e[3:0]});
                    if (e[3:0] == 4'd5) begin
                        @(negedge clk);
                        check("clr_hold", {12'h0, flag}, 16'd5);
                        @(negedge clk);
                        check("clr_end", {12'h0, flag}, 16'd0);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        btn_n      = 8'hFF;
        timer_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", {12'h0, state}, 16'd1);
        check("rst_flag", {12'h0, flag}, 16'd0);
        check("rst_evt", {8'h00, btn_evt}, 16'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // short glitches must be filtered, then a long hold gives one event
        repeat (3) glitch(1);
        press(8'h02, 40);
        press_rand(8'h02);
        press_rand(8'h02);
        press_rand(8'h06);
        press_rand(8'h06);
        press_rand(8'h02);

        // asynchronous reset while the stopwatch runs
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_flag", {12'h0, flag}, 16'd0);
        check("arst_state", {12'h0, state}, 16'd1);
        check("arst_evt", {8'h00, btn_evt}, 16'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        m_mode = 1;
        m_sw   = 0;
        m_tm   = 0;
        repeat (5) @(negedge clk);
        press_rand(8'h02);

        // mode wrap with the stopwatch running in the background
        repeat (4) press_rand(8'h01);
        press_rand(8'h01);

        // timer sequencing
        press_rand(8'h02);
        pulse_done();
        press_rand(8'h02);
        press_rand(8'h02);
        pulse_done();
        press_rand(8'h02);
        press_rand(8'h04);

        // back to stopwatch; timer_done acts on the timer in the background
        repeat (3) press_rand(8'h01);
        pulse_done();
        press_rand(8'h03);
        repeat (3) press_rand(8'h01);

        // extra pass-through buttons produce events with no action
        press_rand(8'hA0);

        repeat (10) @(negedge clk);
        check("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
